// File: rtl/led_status.sv
// Fixture status to blink-coded, brightness-limited RGB LED drive (blue = running, green = pass, red = fail).
// Define LED_STATUS_FAIL_BLINK_EN to make the FAIL colour blink instead of holding steady.
module led_status #(
  parameter int unsigned CLK_FREQ = 48_000_000,
  parameter int unsigned BLINK_HZ = 2,
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned DUTY     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_running,
  input  logic       i_passed,
  output logic       o_led_r,
  output logic       o_led_g,
  output logic       o_led_b,
  output logic       o_done,
  output logic [7:0] o_pass_cnt
);

  localparam int unsigned HALF    = CLK_FREQ / (2 * BLINK_HZ);
  localparam int unsigned BLINK_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned CMP_W   = PWM_BITS + 1;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t               state;
  logic                 run_q;
  logic                 phase;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [BLINK_W-1:0]   blink_cnt;

  logic                 rise_c;
  logic                 fall_c;
  logic                 gate_c;
  logic                 blink_wrap_c;
  logic [BLINK_W-1:0]   blink_nxt_c;
  logic                 phase_nxt_c;

  assign rise_c       = i_running & ~run_q;
  assign fall_c       = ~i_running & run_q;
  // Extra bit lets DUTY == 2**PWM_BITS mean always on.
  assign gate_c       = CMP_W'(pwm_cnt) < CMP_W'(DUTY);
  assign blink_wrap_c = (blink_cnt == BLINK_W'(HALF - 1));
  assign blink_nxt_c  = blink_wrap_c ? '0 : blink_cnt + 1'b1;
  assign phase_nxt_c  = phase ^ blink_wrap_c;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      run_q      <= 1'b0;
      phase      <= 1'b1;
      pwm_cnt    <= '0;
      blink_cnt  <= '0;
      o_led_r    <= 1'b0;
      o_led_g    <= 1'b0;
      o_led_b    <= 1'b0;
      o_done     <= 1'b0;
      o_pass_cnt <= 8'd0;
    end else begin
      run_q   <= i_running;
      pwm_cnt <= pwm_cnt + 1'b1;
      o_done  <= 1'b0;
      o_led_r <= 1'b0;
      o_led_g <= 1'b0;
      o_led_b <= 1'b0;

      case (state)
        IDLE: begin
          blink_cnt <= '0;
          if (rise_c) begin
            state <= RUN;
            phase <= 1'b1;
          end
        end

        RUN: begin
          o_led_b <= phase & gate_c;
          if (fall_c) begin
            o_done    <= 1'b1;
            blink_cnt <= '0;
            if (i_passed) begin
              state <= PASS;
              if (o_pass_cnt != 8'hFF) o_pass_cnt <= o_pass_cnt + 8'd1;
            end else begin
              state <= FAIL;
`ifdef LED_STATUS_FAIL_BLINK_EN
              phase <= 1'b1;
`endif
            end
          end else begin
            blink_cnt <= blink_nxt_c;
            phase     <= phase_nxt_c;
          end
        end

        PASS: begin
          o_led_g   <= gate_c;
          blink_cnt <= '0;
          if (rise_c) begin
            state <= RUN;
            phase <= 1'b1;
          end
        end

        FAIL: begin
`ifdef LED_STATUS_FAIL_BLINK_EN
          o_led_r <= phase & gate_c;
          if (rise_c) begin
            state     <= RUN;
            phase     <= 1'b1;
            blink_cnt <= '0;
          end else begin
            blink_cnt <= blink_nxt_c;
            phase     <= phase_nxt_c;
          end
`else
          o_led_r   <= gate_c;
          blink_cnt <= '0;
          if (rise_c) begin
            state <= RUN;
            phase <= 1'b1;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_status.sv
// Scoreboard bench for led_status: DUTY=2 main instance plus DUTY=0 and DUTY=4 companions on shared stimulus.
module tb_led_status;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_PASS = 2;
  localparam int S_FAIL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       running;
  logic       passed;
  logic       r2, g2, b2, d2;
  logic       r0, g0, b0, d0;
  logic       r4, g4, b4, d4;
  logic [7:0] c2, c0, c4;

  led_status #(.CLK_FREQ(16), .BLINK_HZ(2), .PWM_BITS(2), .DUTY(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_running(running), .i_passed(passed),
    .o_led_r(r2), .o_led_g(g2), .o_led_b(b2), .o_done(d2), .o_pass_cnt(c2));

  led_status #(.CLK_FREQ(16), .BLINK_HZ(2), .PWM_BITS(2), .DUTY(0)) dut_off (
    .i_clk(clk), .i_rst(rst), .i_running(running), .i_passed(passed),
    .o_led_r(r0), .o_led_g(g0), .o_led_b(b0), .o_done(d0), .o_pass_cnt(c0));

  led_status #(.CLK_FREQ(16), .BLINK_HZ(2), .PWM_BITS(2), .DUTY(4)) dut_full (
    .i_clk(clk), .i_rst(rst), .i_running(running), .i_passed(passed),
    .o_led_r(r4), .o_led_g(g4), .o_led_b(b4), .o_done(d4), .o_pass_cnt(c4));

  always #5 clk = ~clk;

  // Number of posedges seen so far; stable when sampled on the negedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] rgb2;
    logic [2:0] rgb4;
    logic       done;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  int   rst_edge  = 0;
  int   cur_st    = S_IDLE;
  int   cur_start = 0;
  int   exp_cnt   = 0;

  // PWM counter is 0 just after the reset edge, so value before posedge n is (n-1-rst_edge) mod 4.
  function automatic logic gate(int n, bit full);
    if (full) return 1'b1;
    return ((n - 1 - rst_edge) % 4) < 2;
  endfunction

  // Blink phase before posedge n for a blink that started (phase=1, count=0) at posedge start.
  function automatic logic ph(int n, int start);
    return (((n - start - 1) / 4) % 2) == 0;
  endfunction

  function automatic logic [2:0] colour(int st, int start, int n, bit full);
    logic g;
    g = gate(n, full);
    case (st)
      S_RUN:  return {2'b00, ph(n, start) & g};
      S_PASS: return {1'b0, g, 1'b0};
`ifdef LED_STATUS_FAIL_BLINK_EN
      S_FAIL: return {ph(n, start) & g, 2'b00};
`else
      S_FAIL: return {g, 2'b00};
`endif
      default: return 3'b000;
    endcase
  endfunction

  task automatic push(int n, logic done);
    exp_t e;
    e.cyc  = n;
    e.rgb2 = colour(cur_st, cur_start, n, 1'b0);
    e.rgb4 = colour(cur_st, cur_start, n, 1'b1);
    e.done = done;
    e.cnt  = 8'(exp_cnt);
    q.push_back(e);
  endtask

  task automatic do_reset();
    int n;
    n       = cyc;
    rst     = 1'b1;
    running = 1'b0;
    passed  = 1'b0;
    exp_cnt = 0;
    cur_st  = S_IDLE;
    push(n + 1, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    rst_edge = cyc;
  endtask

  task automatic hold(int l);
    int n;
    n = cyc;
    for (int i = 1; i <= l; i++) push(n + i, 1'b0);
    repeat (l) @(negedge clk);
  endtask

  task automatic rise();
    int n;
    n       = cyc;
    running = 1'b1;
    push(n + 1, 1'b0);
    cur_st    = S_RUN;
    cur_start = n + 1;
    @(negedge clk);
  endtask

  task automatic fall(logic p);
    int n;
    n       = cyc;
    running = 1'b0;
    passed  = p;
    if (p && exp_cnt < 255) exp_cnt = exp_cnt + 1;
    push(n + 1, 1'b1);
    cur_st    = p ? S_PASS : S_FAIL;
    cur_start = n + 1;
    @(negedge clk);
  endtask

  // Monitor: every cycle with a queued expectation is compared against all three instances.
  always @(negedge clk) begin
    exp_t        e;
    logic [35:0] act;
    logic [35:0] req;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL stale_exp cyc=%0d expected entry for cyc=%0d never checked", cyc, e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e   = q.pop_front();
      act = {r2, g2, b2, r4, g4, b4, r0, g0, b0, d2, d4, d0, c2, c4, c0};
      req = {e.rgb2, e.rgb4, 3'b000, e.done, e.done, e.done, e.cnt, e.cnt, e.cnt};
      tests = tests + 1;
      if (act !== req) begin
        fails = fails + 1;
        $display("FAIL outputs cyc=%0d got=%h want=%h (rgb2 rgb4 rgb0 done x3 cnt x3)",
                 cyc, act, req);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and idle: everything dark, no done, count zero.
    do_reset();
    hold(20);

    // Running: gated blue, 4 cycles on / 4 off; passed wiggles are ignored.
    rise();
    hold(7);
    passed = 1'b1;
    hold(6);
    passed = 1'b0;
    hold(7);

    // Pass result: one done pulse, gated steady green, count 1.
    fall(1'b1);
    hold(12);

    // Rerun and fail: red, count unchanged.
    rise();
    hold(9);
    fall(1'b0);
    hold(12);

    // Back-to-back one-cycle runs saturate the pass counter.
    for (int i = 0; i < 300; i++) begin
      rise();
      fall(1'b1);
    end
    hold(4);

    // Rerun from FAIL state once to check re-arm out of FAIL.
    rise();
    hold(3);
    fall(1'b0);
    hold(5);
    rise();
    hold(2);

    // Reset in the middle of a run, then restart.
    do_reset();
    hold(3);
    rise();
    hold(10);
    fall(1'b1);
    hold(4);

    repeat (3) @(negedge clk);
    tests = tests + 1;
    if (q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL queue_drain got=%0d entries left want=0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
